// File: rtl/seq_detect_if.sv
// Host-side bundle for seq_detect_ctrl: config, command, serial input and status.
interface seq_detect_if #(
   parameter int MAX_LEN = 5,
   parameter int CNT_W   = 8
);
   localparam int LW = $clog2(MAX_LEN + 1);

   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LW-1:0]      cfg_len;
   logic               cfg_overlap;
   logic [CNT_W-1:0]   cfg_target;
   logic               start;
   logic               abort;
   logic               din;
   logic               din_valid;
   logic               z;
   logic [CNT_W-1:0]   match_cnt;
   logic               busy;
   logic               done;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      output start, abort, din, din_valid,
      input  z, match_cnt, busy, done
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
      input  start, abort, din, din_valid,
      output z, match_cnt, busy, done
   );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector with arm/abort control, overlap rule,
// saturating match counter and stop-at-target.
//   state   | meaning
//   S_IDLE  | disarmed, config writable, din ignored
//   S_ARMED | sampling din, counting matches, config locked
//   S_DONE  | target reached, done=1, count held, config writable
module seq_detect_ctrl #(
   parameter int                 MAX_LEN     = 5,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = 5'b11011,
   parameter int                 DEF_LEN     = 5
) (
   input logic         clk,
   input logic         reset,
   seq_detect_if.slave bus
);
   localparam int LW = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

   state_t             state, state_nx;
   logic [MAX_LEN-1:0] pat_r;
   logic [LW-1:0]      len_r;
   logic               ovl_r;
   logic [CNT_W-1:0]   tgt_r;
   logic [MAX_LEN-2:0] hist;
   logic [LW-1:0]      fill;
   logic [CNT_W-1:0]   cnt;
   logic               z_r;

   logic [MAX_LEN-1:0] window, mask;
   logic [LW:0]        fill_inc;
   logic [CNT_W-1:0]   cnt_inc;
   logic               sample, match, hit, clr, cfg_take;

   function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
      if (l == '0)
         return LW'(1);
      else if (l > LW'(MAX_LEN))
         return LW'(MAX_LEN);
      else
         return l;
   endfunction

   always_comb begin
      window   = {hist, bus.din};
      mask     = '0;
      for (int i = 0; i < MAX_LEN; i++)
         mask[i] = (i < int'(len_r));
      // abort outranks a coincident match, so it gates sampling entirely
      sample   = (state == S_ARMED) && bus.din_valid && !bus.abort;
      fill_inc = {1'b0, fill} + (LW+1)'(1);
      match    = sample && (fill_inc >= {1'b0, len_r}) && (((window ^ pat_r) & mask) == '0);
      cnt_inc  = (cnt == '1) ? cnt : cnt + CNT_W'(1);
      hit      = match && (tgt_r != '0) && (cnt_inc == tgt_r);
      clr      = bus.start && !bus.abort && (state != S_ARMED);
      cfg_take = bus.cfg_we && (state != S_ARMED);

      state_nx = state;
      case (state)
         S_IDLE:  if (clr) state_nx = S_ARMED;
         S_ARMED: if (bus.abort) state_nx = S_IDLE;
                  else if (hit) state_nx = S_DONE;
         S_DONE:  if (clr) state_nx = S_ARMED;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pat_r <= DEF_PATTERN;
         len_r <= LW'(DEF_LEN);
         ovl_r <= 1'b1;
         tgt_r <= '0;
         hist  <= '0;
         fill  <= '0;
         cnt   <= '0;
         z_r   <= 1'b0;
      end else begin
         if (cfg_take) begin
            pat_r <= bus.cfg_pattern;
            len_r <= clamp_len(bus.cfg_len);
            ovl_r <= bus.cfg_overlap;
            tgt_r <= bus.cfg_target;
         end
         if (clr) begin
            hist <= '0;
            fill <= '0;
            cnt  <= '0;
         end else if (sample) begin
            hist <= window[MAX_LEN-2:0];
            if (match && !ovl_r)
               fill <= '0;
            else if (fill_inc >= {1'b0, len_r})
               fill <= len_r;
            else
               fill <= fill_inc[LW-1:0];
            if (match)
               cnt <= cnt_inc;
         end
         z_r <= match;
      end
   end

   assign bus.z         = z_r;
   assign bus.match_cnt = cnt;
   assign bus.busy      = (state == S_ARMED);
   assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed, table-driven bench for seq_detect_ctrl with a saturation sequence.
module tb_seq_detect_ctrl;
   logic clk;
   logic reset;

   seq_detect_if #(.MAX_LEN(5), .CNT_W(8)) bus ();

   seq_detect_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       we;
      logic [4:0] pat;
      logic [2:0] len;
      logic       ovl;
      logic [7:0] tgt;
      logic       st;
      logic       ab;
      logic       din;
      logic       dv;
      logic       ez;
      logic [7:0] ecnt;
      logic       eb;
      logic       ed;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void v(input logic rst, we, input logic [4:0] pat, input logic [2:0] len,
                             input logic ovl, input logic [7:0] tgt, input logic st, ab, din, dv,
                             input logic ez, input logic [7:0] ecnt, input logic eb, ed);
      vec_t t;
      t.rst = rst; t.we = we; t.pat = pat; t.len = len; t.ovl = ovl; t.tgt = tgt;
      t.st = st; t.ab = ab; t.din = din; t.dv = dv;
      t.ez = ez; t.ecnt = ecnt; t.eb = eb; t.ed = ed;
      tbl.push_back(t);
   endfunction

   function automatic void b(input logic din, dv, ez, input logic [7:0] c, input logic eb, ed);
      v(0, 0, 5'd0, 3'd0, 0, 8'd0, 0, 0, din, dv, ez, c, eb, ed);
   endfunction

   function automatic void ctl(input logic st, ab, din, dv, ez, input logic [7:0] c, input logic eb, ed);
      v(0, 0, 5'd0, 3'd0, 0, 8'd0, st, ab, din, dv, ez, c, eb, ed);
   endfunction

   function automatic void cfg(input logic [4:0] pat, input logic [2:0] len, input logic ovl,
                               input logic [7:0] tgt, input logic [7:0] c, input logic eb, ed);
      v(0, 1, pat, len, ovl, tgt, 0, 0, 0, 0, 0, c, eb, ed);
   endfunction

   task automatic drive(input vec_t t);
      reset           = t.rst;
      bus.cfg_we      = t.we;
      bus.cfg_pattern = t.pat;
      bus.cfg_len     = t.len;
      bus.cfg_overlap = t.ovl;
      bus.cfg_target  = t.tgt;
      bus.start       = t.st;
      bus.abort       = t.ab;
      bus.din         = t.din;
      bus.din_valid   = t.dv;
   endtask

   task automatic chk(input int id, input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step%0d %s got %0d want %0d", id, nm, act, exp);
      end
   endtask

   task automatic chk_all(input int id, input logic ez, input logic [7:0] ec, input logic eb, ed);
      chk(id, "z", {7'd0, bus.z}, {7'd0, ez});
      chk(id, "match_cnt", bus.match_cnt, ec);
      chk(id, "busy", {7'd0, bus.busy}, {7'd0, eb});
      chk(id, "done", {7'd0, bus.done}, {7'd0, ed});
   endtask

   initial begin
      vec_t idle_v;
      reset = 1'b0; bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
      bus.cfg_target = 0; bus.start = 0; bus.abort = 0; bus.din = 0; bus.din_valid = 0;

      // reset, then default config / overlap / run forever
      v(1, 0, 5'd0, 3'd0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd0, 0, 0);
      cfg(5'b11011, 3'd5, 1, 8'd0, 8'd0, 0, 0);
      ctl(1, 0, 0, 0, 0, 8'd0, 1, 0);
      b(1,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(0,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(1,1,1,8'd1,1,0);
      b(0,1,0,8'd1,1,0);
      ctl(1, 0, 0, 0, 0, 8'd1, 1, 0);
      b(1,1,0,8'd1,1,0); b(1,1,1,8'd2,1,0); b(0,1,0,8'd2,1,0); b(1,1,0,8'd2,1,0); b(1,1,1,8'd3,1,0);
      b(0,0,0,8'd3,1,0);
      ctl(0, 1, 0, 0, 0, 8'd3, 0, 0);

      // non-overlapping
      cfg(5'b11011, 3'd5, 0, 8'd0, 8'd3, 0, 0);
      ctl(1, 0, 0, 0, 0, 8'd0, 1, 0);
      b(1,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(0,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(1,1,1,8'd1,1,0);
      b(0,1,0,8'd1,1,0); b(1,1,0,8'd1,1,0); b(1,1,0,8'd1,1,0); b(0,1,0,8'd1,1,0); b(1,1,0,8'd1,1,0);
      b(1,1,1,8'd2,1,0);
      ctl(0, 1, 0, 0, 0, 8'd2, 0, 0);

      // target 2 -> DONE after bit 8
      cfg(5'b11011, 3'd5, 1, 8'd2, 8'd2, 0, 0);
      ctl(1, 0, 0, 0, 0, 8'd0, 1, 0);
      b(1,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(0,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(1,1,1,8'd1,1,0);
      b(0,1,0,8'd1,1,0); b(1,1,0,8'd1,1,0); b(1,1,1,8'd2,0,1);
      b(0,1,0,8'd2,0,1); b(1,1,0,8'd2,0,1); b(1,1,0,8'd2,0,1);

      // config in DONE, restart, valid gaps, write during ARMED ignored
      cfg(5'b11011, 3'd5, 1, 8'd0, 8'd2, 0, 1);
      ctl(1, 0, 0, 0, 0, 8'd0, 1, 0);
      b(1,1,0,8'd0,1,0); b(0,0,0,8'd0,1,0); b(1,1,0,8'd0,1,0);
      v(0, 1, 5'b00101, 3'd3, 1, 8'd0, 0, 0, 0, 0, 0, 8'd0, 1, 0);
      b(0,1,0,8'd0,1,0); b(1,0,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(0,0,0,8'd0,1,0);
      b(1,1,1,8'd1,1,0); b(0,0,0,8'd1,1,0);
      ctl(0, 1, 0, 0, 0, 8'd1, 0, 0);

      // abort coincident with a match; start+abort; restart clears count
      ctl(1, 0, 0, 0, 0, 8'd0, 1, 0);
      b(1,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(0,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(1,1,1,8'd1,1,0);
      b(0,1,0,8'd1,1,0); b(1,1,0,8'd1,1,0);
      ctl(0, 1, 1, 1, 0, 8'd1, 0, 0);
      ctl(0, 0, 0, 0, 0, 8'd1, 0, 0);
      ctl(1, 1, 0, 0, 0, 8'd1, 0, 0);
      ctl(1, 0, 0, 0, 0, 8'd0, 1, 0);
      ctl(0, 1, 0, 0, 0, 8'd0, 0, 0);

      // len 0 stored as 1, then reset mid-run restores default config
      cfg(5'b00001, 3'd0, 1, 8'd0, 8'd0, 0, 0);
      ctl(1, 0, 0, 0, 0, 8'd0, 1, 0);
      b(1,1,1,8'd1,1,0); b(0,1,0,8'd1,1,0); b(1,1,1,8'd2,1,0); b(1,1,1,8'd3,1,0);
      v(1, 0, 5'd0, 3'd0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd0, 0, 0);
      ctl(1, 0, 0, 0, 0, 8'd0, 1, 0);
      b(1,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(0,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(1,1,1,8'd1,1,0);
      ctl(0, 1, 0, 0, 0, 8'd1, 0, 0);

      // len 7 clamps to 5
      cfg(5'b11111, 3'd7, 1, 8'd0, 8'd1, 0, 0);
      ctl(1, 0, 0, 0, 0, 8'd0, 1, 0);
      b(1,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(1,1,0,8'd0,1,0); b(1,1,1,8'd1,1,0);
      b(1,1,1,8'd2,1,0);
      ctl(0, 1, 0, 0, 0, 8'd2, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i]);
         @(posedge clk);
         #1;
         chk_all(i, tbl[i].ez, tbl[i].ecnt, tbl[i].eb, tbl[i].ed);
      end

      // counter saturation: len 1 pattern 1, a 1 on every cycle
      idle_v = tbl[0];
      idle_v.rst = 0; idle_v.we = 1; idle_v.pat = 5'b00001; idle_v.len = 3'd1;
      idle_v.ovl = 1; idle_v.tgt = 8'd0; idle_v.st = 1; idle_v.ab = 0; idle_v.din = 0; idle_v.dv = 0;
      @(negedge clk);
      drive(idle_v);
      @(posedge clk);
      #1;
      chk_all(1000, 1'b0, 8'd0, 1'b1, 1'b0);
      idle_v.we = 0; idle_v.st = 0; idle_v.din = 1; idle_v.dv = 1;
      for (int n = 1; n <= 260; n++) begin
         @(negedge clk);
         drive(idle_v);
         @(posedge clk);
         #1;
         chk(1000 + n, "sat_z", {7'd0, bus.z}, 8'd1);
         chk(1000 + n, "sat_cnt", bus.match_cnt, (n > 255) ? 8'd255 : 8'(n));
      end
      chk(2000, "sat_busy", {7'd0, bus.busy}, 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
